zoom_sequencer: RTL and testbench

Parametrised zoom/algorithm controller between the user push-buttons and the scaling coprocessor. Cycles through `N_ALGS` scaling algorithms and walks a signed zoom level between `-MAX_LEVEL` and `+MAX_LEVEL`. Each zoom step is issued to the coprocessor with a START/DONE handshake and a timeout. The level commits only on DONE, and `IMAGE_STATE` is derived from the committed level.

---
 rtl/zoom_sequencer_pkg.sv | 26 ++
 rtl/zoom_sequencer_button_sync_edge.sv | 43 ++++
 rtl/zoom_sequencer.sv | 161 ++++++++++++++++
 tb/tb_zoom_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_sequencer_pkg.sv
// Shared encodings for the zoom sequencer: image classification and FSM states.
package zoom_pkg;

   typedef enum logic [1:0] {
      IMG_DEFAULT  = 2'd0,
      IMG_ENLARGED = 2'd1,
      IMG_REDUCED  = 2'd2
   } image_state_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   // Classify a level from its zero flag and sign bit.
   function automatic image_state_e image_state_of(input logic is_zero, input logic is_neg);
      if (is_zero) begin
         return IMG_DEFAULT;
      end else if (is_neg) begin
         return IMG_REDUCED;
      end
      return IMG_ENLARGED;
   endfunction

endpackage

// File: rtl/zoom_sequencer_button_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a press
// detector yielding one single-cycle pulse per press, however long it is held.
module button_sync_edge #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic BTN_IN,
   output logic PRESS
);

   localparam logic IDLE_LVL = ACTIVE_LOW;

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;

   // Shift chain: metastability stage, stable stage, one-cycle history.
   always_comb begin
      sync1_d = BTN_IN;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Flops reset to the released button level so no press appears on reset exit.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
         prev_q  <= IDLE_LVL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // Press = synchronised button just became active.
   always_comb begin
      PRESS = (sync2_q ^ IDLE_LVL) & ~(prev_q ^ IDLE_LVL);
   end

endmodule

// File: rtl/zoom_sequencer.sv
// Zoom/algorithm controller: cycles the scaling algorithm on SELECT, issues one
// zoom step per ZOOM_REQ to the coprocessor with START/DONE and a timeout, and
// commits the zoom level only when the coprocessor reports DONE.
module zoom_sequencer
   import zoom_pkg::*;
#(
   parameter int                N_ALGS         = 4,
   parameter logic [N_ALGS-1:0] ENLARGE_MASK   = 4'b0011,
   parameter int                MAX_LEVEL      = 2,
   parameter int                TIMEOUT_CYCLES = 1024,
   localparam int               ALG_W          = (N_ALGS > 2) ? $clog2(N_ALGS) : 1,
   localparam int               LVL_W          = $clog2(MAX_LEVEL + 1) + 1
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    SELECT,
   input  logic                    ZOOM_REQ,
   input  logic                    DONE,
   output logic [ALG_W-1:0]        ALGORITHM,
   output logic signed [LVL_W-1:0] ZOOM_LEVEL,
   output logic signed [LVL_W-1:0] TARGET_LEVEL,
   output logic [1:0]              IMAGE_STATE,
   output logic                    START,
   output logic                    BUSY,
   output logic                    REJECT,
   output logic                    TIMEOUT_ERR
);

   localparam int                    CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ALG_W-1:0]      ALG_LAST = ALG_W'(N_ALGS - 1);
   localparam int                    MASK_W   = 1 << ALG_W;
   // Mask widened to every encodable index so unused codes read as "reduce".
   localparam logic [MASK_W-1:0]     MASK_EXT = MASK_W'(ENLARGE_MASK);
   localparam logic signed [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
   localparam logic signed [LVL_W-1:0] LVL_MIN = LVL_W'(-MAX_LEVEL);
   localparam logic signed [LVL_W-1:0] LVL_ONE = LVL_W'(1);

   state_e                  state_q, state_d;
   logic [ALG_W-1:0]        alg_q, alg_d;
   logic signed [LVL_W-1:0] zoom_level_q, zoom_level_d;
   logic signed [LVL_W-1:0] target_level_q, target_level_d;
   image_state_e            image_state_q, image_state_d;
   logic                    reject_q, reject_d;
   logic                    timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    sel_press;
   logic                    zoom_press;
   logic                    enlarge;
   logic                    can_step;
   logic signed [LVL_W-1:0] step_level;

   button_sync_edge #(.ACTIVE_LOW(1'b1)) u_sel_sync (
      .CLK    (CLK),
      .RESET  (RESET),
      .BTN_IN (SELECT),
      .PRESS  (sel_press)
   );

   button_sync_edge #(.ACTIVE_LOW(1'b0)) u_zoom_sync (
      .CLK    (CLK),
      .RESET  (RESET),
      .BTN_IN (ZOOM_REQ),
      .PRESS  (zoom_press)
   );

   // Direction and range check for the step the current algorithm would take.
   always_comb begin
      enlarge    = MASK_EXT[alg_q];
      can_step   = enlarge ? (zoom_level_q != LVL_MAX) : (zoom_level_q != LVL_MIN);
      step_level = enlarge ? (zoom_level_q + LVL_ONE) : (zoom_level_q - LVL_ONE);
   end

   // Next-state logic: event handling, job handshake and timeout.
   always_comb begin
      state_d        = state_q;
      alg_d          = alg_q;
      zoom_level_d   = zoom_level_q;
      target_level_d = target_level_q;
      reject_d       = 1'b0;
      timeout_err_d  = 1'b0;
      cnt_d          = cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Zoom takes priority; a coincident select is dropped.
            if (zoom_press) begin
               if (can_step) begin
                  target_level_d = step_level;
                  state_d        = ST_ISSUE;
               end else begin
                  reject_d = 1'b1;
               end
            end else if (sel_press) begin
               alg_d = (alg_q == ALG_LAST) ? '0 : alg_q + 1'b1;
            end
         end
         ST_ISSUE: begin
            reject_d = zoom_press;
            cnt_d    = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            reject_d = zoom_press;
            // DONE beats a coincident timeout expiry.
            if (DONE) begin
               zoom_level_d = target_level_q;
               state_d      = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               target_level_d = zoom_level_q;
               timeout_err_d  = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      image_state_d = image_state_of(zoom_level_d == '0, zoom_level_d[LVL_W-1]);
   end

   // State register; reset aborts any job in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         alg_q          <= '0;
         zoom_level_q   <= '0;
         target_level_q <= '0;
         image_state_q  <= IMG_DEFAULT;
         reject_q       <= 1'b0;
         timeout_err_q  <= 1'b0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         alg_q          <= alg_d;
         zoom_level_q   <= zoom_level_d;
         target_level_q <= target_level_d;
         image_state_q  <= image_state_d;
         reject_q       <= reject_d;
         timeout_err_q  <= timeout_err_d;
         cnt_q          <= cnt_d;
      end
   end

   // Output decode.
   always_comb begin
      ALGORITHM    = alg_q;
      ZOOM_LEVEL   = zoom_level_q;
      TARGET_LEVEL = target_level_q;
      IMAGE_STATE  = image_state_q;
      START        = (state_q == ST_ISSUE);
      BUSY         = (state_q != ST_IDLE);
      REJECT       = reject_q;
      TIMEOUT_ERR  = timeout_err_q;
   end

endmodule

// File: tb/tb_zoom_sequencer.sv
// Directed bench for zoom_sequencer: inputs driven and outputs sampled on the
// falling clock edge; a second instance with three algorithms checks wrapping.
module tb_zoom_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic sel_n, zreq, done;
   logic sel3_n, zreq3, done3;

   logic [1:0]        alg, alg3;
   logic signed [2:0] zl, tl, zl3, tl3;
   logic [1:0]        ist, ist3;
   logic              start, busy, reject, terr;
   logic              start3, busy3, reject3, terr3;

   int checks = 0;
   int failures = 0;
   int start_cnt = 0;
   int reject_cnt = 0;
   int terr_cnt = 0;
   int s0, r0, t0, cur;
   int exp_alg [5] = '{1, 2, 3, 0, 1};
   int exp_alg3 [3] = '{1, 2, 0};

   always #5 clk = ~clk;

   zoom_sequencer #(
      .N_ALGS         (4),
      .ENLARGE_MASK   (4'b0011),
      .MAX_LEVEL      (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .SELECT       (sel_n),
      .ZOOM_REQ     (zreq),
      .DONE         (done),
      .ALGORITHM    (alg),
      .ZOOM_LEVEL   (zl),
      .TARGET_LEVEL (tl),
      .IMAGE_STATE  (ist),
      .START        (start),
      .BUSY         (busy),
      .REJECT       (reject),
      .TIMEOUT_ERR  (terr)
   );

   zoom_sequencer #(
      .N_ALGS         (3),
      .ENLARGE_MASK   (3'b011),
      .MAX_LEVEL      (2),
      .TIMEOUT_CYCLES (16)
   ) dut3 (
      .CLK          (clk),
      .RESET        (rst),
      .SELECT       (sel3_n),
      .ZOOM_REQ     (zreq3),
      .DONE         (done3),
      .ALGORITHM    (alg3),
      .ZOOM_LEVEL   (zl3),
      .TARGET_LEVEL (tl3),
      .IMAGE_STATE  (ist3),
      .START        (start3),
      .BUSY         (busy3),
      .REJECT       (reject3),
      .TIMEOUT_ERR  (terr3)
   );

   // Pulse counters for the main instance.
   always @(posedge clk) begin
      if (start)  start_cnt  <= start_cnt + 1;
      if (reject) reject_cnt <= reject_cnt + 1;
      if (terr)   terr_cnt   <= terr_cnt + 1;
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_sel();
      sel_n = 1'b0;
      nclk(4);
      sel_n = 1'b1;
      nclk(4);
   endtask

   // Zoom press up to the START cycle and one cycle into WAIT.
   task automatic start_zoom(input int exp_tl);
      zreq = 1'b1;
      nclk(3);
      chk("start_pulse", int'(start), 1);
      chk("busy_issue", int'(busy), 1);
      chk("target_issue", int'(tl), exp_tl);
      zreq = 1'b0;
      nclk(1);
      chk("start_single", int'(start), 0);
      chk("busy_wait", int'(busy), 1);
   endtask

   // Full job answered by DONE.
   task automatic zoom_job(input int exp_lvl, input int exp_ist);
      start_zoom(exp_lvl);
      nclk(2);
      done = 1'b1;
      nclk(1);
      done = 1'b0;
      chk("commit_level", int'(zl), exp_lvl);
      chk("commit_target", int'(tl), exp_lvl);
      chk("commit_image", int'(ist), exp_ist);
      chk("commit_busy", int'(busy), 0);
      nclk(3);
   endtask

   initial begin
      rst = 1'b1;
      sel_n = 1'b1; zreq = 1'b0; done = 1'b0;
      sel3_n = 1'b1; zreq3 = 1'b0; done3 = 1'b0;
      nclk(3);
      rst = 1'b0;
      nclk(2);
      chk("rst_alg", int'(alg), 0);
      chk("rst_level", int'(zl), 0);
      chk("rst_target", int'(tl), 0);
      chk("rst_image", int'(ist), 0);
      chk("rst_start", int'(start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_reject", int'(reject), 0);
      chk("rst_terr", int'(terr), 0);

      // Five held SELECT presses: one change each, two-cycle latency.
      cur = 0;
      for (int i = 0; i < 5; i++) begin
         sel_n = 1'b0;
         nclk(2);
         chk("sel_latency", int'(alg), cur);
         nclk(1);
         chk("sel_step", int'(alg), exp_alg[i]);
         nclk(7);
         chk("sel_hold", int'(alg), exp_alg[i]);
         sel_n = 1'b1;
         nclk(4);
         cur = exp_alg[i];
      end
      press_sel(); press_sel(); press_sel();
      chk("alg_back_to_0", int'(alg), 0);

      // Enlarge to the limit, third press refused.
      s0 = start_cnt; r0 = reject_cnt;
      zoom_job(1, 1);
      zoom_job(2, 1);
      zreq = 1'b1;
      nclk(3);
      chk("limit_reject", int'(reject), 1);
      chk("limit_busy", int'(busy), 0);
      chk("limit_target", int'(tl), 2);
      zreq = 1'b0;
      nclk(1);
      chk("reject_single", int'(reject), 0);
      nclk(3);
      chk("limit_starts", start_cnt - s0, 2);
      chk("limit_rejects", reject_cnt - r0, 1);
      chk("limit_image", int'(ist), 1);

      // Reduce back to 0 with algorithm 2, then a job that times out.
      press_sel(); press_sel();
      chk("alg_2", int'(alg), 2);
      zoom_job(1, 1);
      zoom_job(0, 0);
      t0 = terr_cnt;
      start_zoom(-1);
      nclk(15);
      chk("to_not_yet", int'(terr), 0);
      chk("to_busy_16th", int'(busy), 1);
      nclk(1);
      chk("to_pulse", int'(terr), 1);
      chk("to_busy", int'(busy), 0);
      chk("to_level", int'(zl), 0);
      chk("to_target", int'(tl), 0);
      chk("to_image", int'(ist), 0);
      nclk(1);
      chk("to_single", int'(terr), 0);
      chk("to_count", terr_cnt - t0, 1);
      nclk(3);

      // Select and zoom during WAIT: select dropped, zoom refused.
      start_zoom(-1);
      sel_n = 1'b0;
      zreq = 1'b1;
      nclk(3);
      chk("wait_reject", int'(reject), 1);
      chk("wait_alg", int'(alg), 2);
      chk("wait_busy", int'(busy), 1);
      chk("wait_target", int'(tl), -1);
      sel_n = 1'b1;
      zreq = 1'b0;
      nclk(1);
      done = 1'b1;
      nclk(1);
      done = 1'b0;
      chk("wait_commit", int'(zl), -1);
      chk("wait_image", int'(ist), 2);
      chk("wait_alg_after", int'(alg), 2);
      nclk(4);

      // Coincident select and zoom with algorithm 1.
      press_sel(); press_sel(); press_sel();
      chk("alg_1", int'(alg), 1);
      sel_n = 1'b0;
      zreq = 1'b1;
      nclk(3);
      chk("simul_alg", int'(alg), 1);
      chk("simul_target", int'(tl), 0);
      chk("simul_start", int'(start), 1);
      sel_n = 1'b1;
      zreq = 1'b0;
      nclk(2);
      done = 1'b1;
      nclk(1);
      done = 1'b0;
      chk("simul_commit", int'(zl), 0);
      chk("simul_alg_after", int'(alg), 1);
      nclk(4);

      // Asynchronous reset in WAIT, late DONE ignored.
      s0 = start_cnt; t0 = terr_cnt;
      start_zoom(1);
      nclk(1);
      rst = 1'b1;
      #1;
      chk("async_busy", int'(busy), 0);
      chk("async_target", int'(tl), 0);
      chk("async_alg", int'(alg), 0);
      nclk(2);
      rst = 1'b0;
      done = 1'b1;
      nclk(2);
      done = 1'b0;
      chk("late_level", int'(zl), 0);
      chk("late_target", int'(tl), 0);
      chk("late_image", int'(ist), 0);
      chk("late_busy", int'(busy), 0);
      chk("late_starts", start_cnt - s0, 1);
      chk("late_terr", terr_cnt - t0, 0);

      // Three-algorithm instance wraps 2 -> 0.
      for (int i = 0; i < 3; i++) begin
         sel3_n = 1'b0;
         nclk(3);
         chk("n3_alg", int'(alg3), exp_alg3[i]);
         sel3_n = 1'b1;
         nclk(4);
      end
      chk("n3_busy", int'(busy3), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
